spu32_cpu_mulseq: RTL and testbench
===================================

SPU32_CPU_MULSEQ -- requirements
Module: spu32_cpu_mulseq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits.
REQ-002 SHALL have parameter STEP, default 2, multiplier bits consumed per RUN cycle; WIDTH % STEP != 0 SHALL fail elaboration.
REQ-003 I_clk  input  1  sole clock; all state changes on rising edge.
REQ-004 I_reset  input  1  asynchronous, active-high reset.
REQ-005 I_en  input  1  start request, sampled only in IDLE.
REQ-006 I_op  input  4  ALUOP_MUL / ALUOP_MULH / ALUOP_MULHSU / ALUOP_MULHU code.
REQ-007 I_s1, I_s2  input  WIDTH  operands.
REQ-008 O_result  output  2*WIDTH  full product, signedness per I_op.
REQ-009 O_busy  output  1  high while an operation is accepted or in progress.
REQ-010 O_done  output  1  one-cycle pulse in the first cycle after completion.

Function
REQ-011 States SHALL be IDLE, RUN, FIXUP.
REQ-012 IDLE with I_en=1: latch operand magnitudes, operation sign (s1_neg XOR s2_neg) and iteration count; O_busy combinationally high in this accept cycle; next state RUN.
REQ-013 Signedness: MULH s1 and s2 signed; MULHSU s1 signed, s2 unsigned; MUL and MULHU both unsigned; MUL low WIDTH bits are identical under any signedness.
REQ-014 Negative signed operands SHALL be converted to two's-complement magnitude at accept; magnitude of the most negative value is 2^(WIDTH-1), unsigned.
REQ-015 RUN, per cycle: acc += mcand * mplier[STEP-1:0]; mcand <<= STEP; mplier >>= STEP; exactly WIDTH/STEP RUN cycles, then FIXUP.
REQ-016 FIXUP: O_result <= sign ? -acc : acc (2*WIDTH-bit arithmetic, modulo 2^(2*WIDTH)); next state IDLE.
REQ-017 O_busy SHALL be high in the accept cycle, all RUN cycles and the FIXUP cycle, and low otherwise; default latency at WIDTH=32, STEP=2 is 18 busy cycles.
REQ-018 O_done SHALL be high for exactly the first IDLE cycle after FIXUP.
REQ-019 O_result SHALL hold its value from FIXUP until the next FIXUP; it SHALL not change during RUN.
REQ-020 I_en, I_op, I_s1 and I_s2 SHALL be ignored while in RUN or FIXUP; operands need not be held stable after accept.
REQ-021 An I_en in the O_done cycle SHALL be accepted as a new operation.

Reset
REQ-022 I_reset=1 SHALL immediately force IDLE, O_result=0, O_busy=0, O_done=0 and clear acc/mcand/mplier, in any state, including mid-RUN.
REQ-023 With I_reset and I_en both high, reset SHALL win and no operation is accepted.
REQ-024 I_en in the first clock edge after reset deassertion SHALL be accepted normally.

Configuration
REQ-025 Macro SPU32_MULSEQ_EARLY_OUT_EN defined: in RUN, when the post-shift mplier equals 0, the next state SHALL be FIXUP regardless of the remaining count; the result is identical.
REQ-026 Macro undefined: RUN always lasts exactly WIDTH/STEP cycles, giving data-independent latency.

Structure
REQ-027 ALUOP_* codes SHALL come from the shared cpu/aludefs.vh; state encodings and the STEP-wide partial-product width SHALL be local parameters.
REQ-028 One sub-module, spu32_cpu_mulseq_step (combinational STEP x 2*WIDTH partial product plus accumulate), is natural; the FSM and registers stay in the top module.

Verification (WIDTH=32, STEP=2)
REQ-029 MULHU 0xFFFFFFFF*0xFFFFFFFF, macro off -> O_result=0xFFFFFFFE_00000001, O_busy high 18 cycles, then one O_done pulse.
REQ-030 MULH 0xFFFFFFFF*0x00000002 -> 0xFFFFFFFF_FFFFFFFE; MULH 0x80000000*0x80000000 -> 0x40000000_00000000.
REQ-031 MULHSU 0x80000000*0xFFFFFFFF -> 0x80000000_80000000; MUL 0x80000000*0xFFFFFFFF -> low word 0x80000000.
REQ-032 Reset pulse asserted in the 5th RUN cycle -> O_busy=0 and O_result=0 immediately, no O_done; MULHU 3*5 accepted next -> 0x00000000_0000000F.
REQ-033 MUL 7*3: macro on -> O_busy high 3 cycles (accept, 1 RUN, FIXUP), result 21; macro off -> 18 cycles, result 21.
REQ-034 I_en toggled with new operands during RUN -> no effect; original result delivered; I_en in the O_done cycle is accepted.

Source files
------------

// File: rtl/spu32_cpu_mulseq_pkg.sv
// rtl/spu32_cpu_mulseq_pkg.sv - ALU multiply opcodes, FSM states and signedness helpers
package spu32_cpu_mulseq_pkg;

    localparam logic [3:0] ALUOP_MUL    = 4'b1010;
    localparam logic [3:0] ALUOP_MULH   = 4'b1011;
    localparam logic [3:0] ALUOP_MULHSU = 4'b1100;
    localparam logic [3:0] ALUOP_MULHU  = 4'b1101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FIXUP = 2'd2
    } mul_state_e;

    function automatic logic op_s1_signed(input logic [3:0] op);
        return (op == ALUOP_MULH) || (op == ALUOP_MULHSU);
    endfunction

    function automatic logic op_s2_signed(input logic [3:0] op);
        return op == ALUOP_MULH;
    endfunction

endpackage

// File: rtl/spu32_cpu_mulseq_step.sv
// rtl/spu32_cpu_mulseq_step.sv - STEP-bit partial product of the multiplicand added to the accumulator
module spu32_cpu_mulseq_step #(
    parameter int WIDTH = 32,
    parameter int STEP  = 2
) (
    input  logic [2*WIDTH-1:0] mcand_i,
    input  logic [STEP-1:0]    bits_i,
    input  logic [2*WIDTH-1:0] acc_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [2*WIDTH-1:0] pp;

    always_comb begin
        pp = '0;
        for (int i = 0; i < STEP; i++) begin
            if (bits_i[i]) begin
                pp = pp + (mcand_i << i);
            end
        end
        acc_o = acc_i + pp;
    end

endmodule

// File: rtl/spu32_cpu_mulseq.sv
// rtl/spu32_cpu_mulseq.sv - sequential shift-add multiplier, STEP bits per cycle; SPU32_MULSEQ_EARLY_OUT_EN enables early exit
module spu32_cpu_mulseq
    import spu32_cpu_mulseq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 2
) (
    input  logic               I_clk,
    input  logic               I_reset,
    input  logic               I_en,
    input  logic [3:0]         I_op,
    input  logic [WIDTH-1:0]   I_s1,
    input  logic [WIDTH-1:0]   I_s2,
    output logic [2*WIDTH-1:0] O_result,
    output logic               O_busy,
    output logic               O_done
);

    localparam int NSTEPS = WIDTH / STEP;
    localparam int CW     = $clog2(NSTEPS + 1);
    localparam int PPW    = STEP;

    generate
        if (WIDTH % STEP != 0) begin : g_step_check
            $error("spu32_cpu_mulseq: WIDTH must be a multiple of STEP");
        end
    endgenerate

    mul_state_e         state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, result_q, result_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               sign_q, sign_d, done_q, done_d;

    logic               s1_neg, s2_neg;
    logic [WIDTH-1:0]   s1_mag, s2_mag, mplier_shr;
    logic [2*WIDTH-1:0] acc_step;

    // Signed operands are reduced to magnitudes; the product sign is reapplied in FIXUP.
    assign s1_neg     = op_s1_signed(I_op) & I_s1[WIDTH-1];
    assign s2_neg     = op_s2_signed(I_op) & I_s2[WIDTH-1];
    assign s1_mag     = s1_neg ? -I_s1 : I_s1;
    assign s2_mag     = s2_neg ? -I_s2 : I_s2;
    assign mplier_shr = mplier_q >> STEP;

    spu32_cpu_mulseq_step #(.WIDTH(WIDTH), .STEP(STEP)) u_step (
        .mcand_i (mcand_q),
        .bits_i  (mplier_q[PPW-1:0]),
        .acc_i   (acc_q),
        .acc_o   (acc_step)
    );

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (I_en) begin
                    state_d  = ST_RUN;
                    acc_d    = '0;
                    mcand_d  = {{WIDTH{1'b0}}, s1_mag};
                    mplier_d = s2_mag;
                    sign_d   = s1_neg ^ s2_neg;
                    cnt_d    = CW'(NSTEPS);
                end
            end
            ST_RUN: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << STEP;
                mplier_d = mplier_shr;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_FIXUP;
                end
`ifdef SPU32_MULSEQ_EARLY_OUT_EN
                if (mplier_shr == '0) begin
                    state_d = ST_FIXUP;
                end
`endif
            end
            ST_FIXUP: begin
                result_d = sign_q ? -acc_q : acc_q;
                state_d  = ST_IDLE;
                done_d   = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign O_busy   = !I_reset && ((state_q != ST_IDLE) || I_en);
    assign O_done   = done_q;
    assign O_result = result_q;

endmodule

// File: tb/tb_spu32_cpu_mulseq.sv
// tb/tb_spu32_cpu_mulseq.sv - randomized and directed checks of spu32_cpu_mulseq against a product/latency model
module tb_spu32_cpu_mulseq;
    import spu32_cpu_mulseq_pkg::*;

    logic        clk = 1'b0;
    logic        I_reset = 1'b1;
    logic        I_en = 1'b0;
    logic [3:0]  I_op = ALUOP_MUL;
    logic [31:0] I_s1 = '0, I_s2 = '0;
    logic [63:0] O_result;
    logic        O_busy, O_done;

    int checks = 0;
    int errors = 0;

`ifdef SPU32_MULSEQ_EARLY_OUT_EN
    localparam int LAT_X2  = 3;
    localparam int LAT_3X5 = 4;
    localparam int LAT_7X3 = 3;
`else
    localparam int LAT_X2  = 18;
    localparam int LAT_3X5 = 18;
    localparam int LAT_7X3 = 18;
`endif

    logic [3:0]  chain_op;
    logic [31:0] chain_a, chain_b;

    spu32_cpu_mulseq #(.WIDTH(32), .STEP(2)) dut (
        .I_clk    (clk),
        .I_reset  (I_reset),
        .I_en     (I_en),
        .I_op     (I_op),
        .I_s1     (I_s1),
        .I_s2     (I_s2),
        .O_result (O_result),
        .O_busy   (O_busy),
        .O_done   (O_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [33:0] ea, eb;
        logic signed [67:0] p;
        ea = (op == ALUOP_MULH || op == ALUOP_MULHSU) ? $signed({{2{a[31]}}, a}) : $signed({2'b00, a});
        eb = (op == ALUOP_MULH) ? $signed({{2{b[31]}}, b}) : $signed({2'b00, b});
        p = ea * eb;
        return p[63:0];
    endfunction

    // Total busy cycles: accept + RUN cycles + FIXUP.
    function automatic int lat_of(input logic [3:0] op, input logic [31:0] b);
        int bl;
        logic [31:0] m;
        m = (op == ALUOP_MULH && b[31]) ? (32'd0 - b) : b;
        bl = 0;
        for (int i = 0; i < 32; i++) if (m[i]) bl = i + 1;
`ifdef SPU32_MULSEQ_EARLY_OUT_EN
        return 2 + ((bl <= 2) ? 1 : (bl + 1) / 2);
`else
        return 2 + 16 + 0 * bl;
`endif
    endfunction

    function automatic logic [3:0] rnd_op();
        case ($urandom_range(0, 3))
            0: return ALUOP_MUL;
            1: return ALUOP_MULH;
            2: return ALUOP_MULHSU;
            default: return ALUOP_MULHU;
        endcase
    endfunction

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic drive_noise();
        I_en = 1'($urandom_range(0, 1));
        I_op = rnd_op();
        I_s1 = rnd_opnd();
        I_s2 = rnd_opnd();
    endtask

    // Cycle-accurate expectations derived from the arithmetic model.
    int          m_left = 0;
    logic        m_done = 1'b0;
    logic [63:0] m_res = '0, m_pend = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (I_reset) begin
                chk("rst_busy", {63'b0, O_busy}, 64'd0);
                chk("rst_done", {63'b0, O_done}, 64'd0);
                chk("rst_result", O_result, 64'd0);
                m_left = 0;
                m_done = 1'b0;
                m_res  = '0;
            end else begin
                if (m_left == 0 && I_en) begin
                    m_left = lat_of(I_op, I_s2);
                    m_pend = ref_prod(I_op, I_s1, I_s2);
                end
                chk("busy", {63'b0, O_busy}, {63'b0, m_left > 0});
                chk("done", {63'b0, O_done}, {63'b0, m_done});
                chk("result", O_result, m_res);
                m_done = (m_left == 1);
                if (m_left == 1) m_res = m_pend;
                if (m_left > 0) m_left--;
            end
        end
    end

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int lat, input bit low_only,
                          input bit chain, input bit already);
        int nbusy;
        @(posedge clk); #2;
        if (!already) begin
            I_reset = 1'b0;
            I_en = 1'b1; I_op = op; I_s1 = a; I_s2 = b;
            nbusy = 0;
        end else begin
            nbusy = 1;
            drive_noise();
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!O_busy || nbusy == lat) break;
            nbusy++;
            @(posedge clk); #2;
            if (nbusy < lat) drive_noise();
            else if (chain) begin
                I_en = 1'b1; I_op = chain_op; I_s1 = chain_a; I_s2 = chain_b;
            end else I_en = 1'b0;
        end
        chk("lat_busy_cycles", 64'(nbusy), 64'(lat));
        chk("lat_done_pulse", {63'b0, O_done}, 64'd1);
        chk("lat_busy_after", {63'b0, O_busy}, {63'b0, chain});
        if (low_only) chk("dir_result_lo", {32'b0, O_result[31:0]}, exp);
        else chk("dir_result", O_result, exp);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("reset_busy", {63'b0, O_busy}, 64'd0);
        chk("reset_result", O_result, 64'd0);

        run_op(ALUOP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 18, 0, 0, 0);
        run_op(ALUOP_MULH, 32'hFFFF_FFFF, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFE, LAT_X2, 0, 0, 0);
        run_op(ALUOP_MULH, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 18, 0, 0, 0);
        run_op(ALUOP_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 64'h8000_0000_8000_0000, 18, 0, 0, 0);
        run_op(ALUOP_MUL, 32'h8000_0000, 32'hFFFF_FFFF, 64'h8000_0000, 18, 1, 0, 0);

        chain_op = ALUOP_MUL; chain_a = 32'd7; chain_b = 32'd3;
        run_op(ALUOP_MULH, 32'hFFFF_FFFF, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFE, LAT_X2, 0, 1, 0);
        run_op(ALUOP_MUL, 32'd7, 32'd3, 64'd21, LAT_7X3, 0, 0, 1);

        // Reset pulse in the fifth RUN cycle, with I_en also high.
        @(posedge clk); #2;
        I_en = 1'b1; I_op = ALUOP_MULHU; I_s1 = 32'h1234_5678; I_s2 = 32'h9ABC_DEF1;
        repeat (4) begin
            @(posedge clk); #2;
            drive_noise();
        end
        @(posedge clk); #2;
        I_reset = 1'b1; I_en = 1'b1;
        @(negedge clk);
        chk("midrun_rst_busy", {63'b0, O_busy}, 64'd0);
        chk("midrun_rst_done", {63'b0, O_done}, 64'd0);
        chk("midrun_rst_result", O_result, 64'd0);
        run_op(ALUOP_MULHU, 32'd3, 32'd5, 64'h0000_0000_0000_000F, LAT_3X5, 0, 0, 0);

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #2;
            I_reset = ($urandom_range(0, 249) == 0);
            I_en = ($urandom_range(0, 3) == 0);
            I_op = rnd_op();
            I_s1 = rnd_opnd();
            I_s2 = rnd_opnd();
        end
        @(posedge clk); #2;
        I_reset = 1'b0;
        I_en = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("drain_idle", {63'b0, O_busy}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
